// File: rtl/handshake_constant_table_pkg.sv
// Shared constants, types and helpers for the handshake constant source
// and its elastic output stage.
package handshake_const_pkg;

  localparam int HC_MODE_FIXED = 0;
  localparam int HC_MODE_CYCLE = 1;

  // Occupancy of the two-entry elastic stage: nothing, main only, main and skid.
  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_MAIN,
    SKID_FULL
  } skid_state_e;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/handshake_constant_table_if.sv
// Control-in / data-out handshake bundle of the constant source.
interface handshake_constant_table_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;

  modport master (
    output ctrl_valid,
    input  ctrl_ready,
    input  outs,
    input  outs_valid,
    output outs_ready
  );

  modport slave (
    input  ctrl_valid,
    output ctrl_ready,
    output outs,
    output outs_valid,
    input  outs_ready
  );

endinterface

// File: rtl/handshake_constant_table_skid.sv
// Generic two-entry elastic register (main + skid) with a registered ready,
// so neither valid nor ready has a combinational path through this stage.
module handshake_skid_buffer
  import handshake_const_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o
);

  skid_state_e           state_q, state_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] mainData_q, mainData_d;
  logic [DATA_WIDTH-1:0] skidData_q, skidData_d;
  logic                  inFire, outFire;

  assign inFire  = in_valid_i && ready_q;
  assign outFire = (state_q != SKID_EMPTY) && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SKID_EMPTY;
      ready_q    <= 1'b0;
      mainData_q <= '0;
      skidData_q <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      mainData_q <= mainData_d;
      skidData_q <= skidData_d;
    end
  end

  // Ready is only ever high when the skid slot is empty, so FULL never sees an accept.
  always_comb begin
    state_d    = state_q;
    mainData_d = mainData_q;
    skidData_d = skidData_q;
    case (state_q)
      SKID_EMPTY: begin
        if (inFire) begin
          state_d    = SKID_MAIN;
          mainData_d = in_data_i;
        end
      end
      SKID_MAIN: begin
        if (inFire && outFire) begin
          mainData_d = in_data_i;
        end else if (inFire) begin
          state_d    = SKID_FULL;
          skidData_d = in_data_i;
        end else if (outFire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (outFire) begin
          state_d    = SKID_MAIN;
          mainData_d = skidData_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    ready_d = (state_d != SKID_FULL);
  end

  always_comb begin
    out_valid_o = (state_q != SKID_EMPTY);
    out_data_o  = mainData_q;
    in_ready_o  = ready_q;
  end

endmodule

// File: rtl/handshake_constant_table.sv
// Turns each accepted control token into one constant from a writable table,
// optionally stepping through the table, and emits it through a skid stage.
module handshake_constant_table
  import handshake_const_pkg::*;
#(
  parameter int                          DATA_WIDTH = 32,
  parameter int                          DEPTH      = 4,
  parameter logic [DEPTH*DATA_WIDTH-1:0] INIT       = '0,
  parameter int                          MODE       = HC_MODE_CYCLE,
  localparam int                         IDX_W      = idx_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  handshake_constant_table_if.slave bus,
  input  logic                  idx_clear_i,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  logic [DATA_WIDTH-1:0] table_q [DEPTH];
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      rdIdx;
  logic                  accept;
  logic [DATA_WIDTH-1:0] tokenData;

  assign accept    = bus.ctrl_valid && bus.ctrl_ready;
  assign rdIdx     = (MODE == HC_MODE_FIXED) ? '0 : idx_q;
  // Reads the pre-write table, so a same-cycle write to this entry lands on the next accept.
  assign tokenData = table_q[rdIdx];

  always_comb begin
    idx_d = idx_q;
    if (idx_clear_i || (MODE == HC_MODE_FIXED)) begin
      idx_d = '0;
    end else if (accept) begin
      idx_d = (idx_q == IDX_W'(DEPTH - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Only addresses that match a real entry are written; anything beyond DEPTH is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= INIT[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en_i && (wr_addr_i == IDX_W'(i))) begin
          table_q[i] <= wr_data_i;
        end
      end
    end
  end

  handshake_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uSkid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bus.ctrl_valid),
    .in_ready_o  (bus.ctrl_ready),
    .in_data_i   (tokenData),
    .out_valid_o (bus.outs_valid),
    .out_ready_i (bus.outs_ready),
    .out_data_o  (bus.outs)
  );

endmodule

// File: tb/tb_handshake_constant_table.sv
// Directed bench for the constant source: one CYCLE instance and one FIXED instance
// sharing clock and reset; inputs change and outputs are sampled on the falling edge.
module tb_handshake_constant_table;
  import handshake_const_pkg::*;

  localparam int DW = 12;
  localparam int DP = 4;
  localparam logic [DP*DW-1:0] INIT_V = {12'h800, 12'h7FF, 12'h0A5, 12'hF32};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          idxClear = 1'b0;
  logic          wrEn = 1'b0;
  logic [1:0]    wrAddr = '0;
  logic [DW-1:0] wrData = '0;
  int            checks = 0;
  int            errors = 0;

  handshake_constant_table_if #(.DATA_WIDTH(DW)) cycBus ();
  handshake_constant_table_if #(.DATA_WIDTH(DW)) fixBus ();

  handshake_constant_table #(
    .DATA_WIDTH(DW), .DEPTH(DP), .INIT(INIT_V), .MODE(HC_MODE_CYCLE)
  ) dutCycle (
    .clk(clk), .rst_n(rst_n), .bus(cycBus),
    .idx_clear_i(idxClear), .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_data_i(wrData)
  );

  handshake_constant_table #(
    .DATA_WIDTH(DW), .DEPTH(DP), .INIT(INIT_V), .MODE(HC_MODE_FIXED)
  ) dutFixed (
    .clk(clk), .rst_n(rst_n), .bus(fixBus),
    .idx_clear_i(1'b0), .wr_en_i(1'b0), .wr_addr_i(2'd0), .wr_data_i(12'd0)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({cycBus.outs_valid, cycBus.ctrl_ready, cycBus.outs} !== {1'b0, 1'b0, 12'h000}) begin
      errors++;
      $display("[TB] FAIL reset_state got=%h want=%h", {cycBus.outs_valid, cycBus.ctrl_ready, cycBus.outs}, 14'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cycBus.ctrl_ready, cycBus.outs_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL ready_after_reset got=%b want=10", {cycBus.ctrl_ready, cycBus.outs_valid});
    end
  endtask

  task automatic test_cycle_stream();
    logic [DW-1:0] exp [6] = '{12'hF32, 12'h0A5, 12'h7FF, 12'h800, 12'hF32, 12'h0A5};
    cycBus.ctrl_valid = 1'b1;
    cycBus.outs_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({cycBus.outs_valid, cycBus.ctrl_ready, cycBus.outs} !== {1'b1, 1'b1, exp[k]}) begin
        errors++;
        $display("[TB] FAIL stream[%0d] got=%h want=%h", k, {cycBus.outs_valid, cycBus.ctrl_ready, cycBus.outs}, {2'b11, exp[k]});
      end
    end
    cycBus.ctrl_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cycBus.outs_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_drain got=%b want=0", cycBus.outs_valid);
    end
  endtask

  task automatic test_idx_clear();
    cycBus.ctrl_valid = 1'b1;
    idxClear = 1'b1;
    @(negedge clk);
    idxClear = 1'b0;
    checks++;
    if (cycBus.outs !== 12'h7FF) begin
      errors++;
      $display("[TB] FAIL clear_token got=%h want=7ff", cycBus.outs);
    end
    @(negedge clk);
    cycBus.ctrl_valid = 1'b0;
    checks++;
    if (cycBus.outs !== 12'hF32) begin
      errors++;
      $display("[TB] FAIL after_clear got=%h want=f32", cycBus.outs);
    end
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [DW-1:0] exp [4] = '{12'h7FF, 12'h800, 12'hF32, 12'h123};
    cycBus.ctrl_valid = 1'b1;
    wrEn = 1'b1;
    wrAddr = 2'd1;
    wrData = 12'h123;
    @(negedge clk);
    wrEn = 1'b0;
    checks++;
    if (cycBus.outs !== 12'h0A5) begin
      errors++;
      $display("[TB] FAIL write_same_cycle got=%h want=0a5", cycBus.outs);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (cycBus.outs !== exp[k]) begin
        errors++;
        $display("[TB] FAIL write_follow[%0d] got=%h want=%h", k, cycBus.outs, exp[k]);
      end
    end
    cycBus.ctrl_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    cycBus.ctrl_valid = 1'b1;
    cycBus.outs_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({cycBus.ctrl_ready, cycBus.outs} !== {1'b1, 12'h7FF}) begin
      errors++;
      $display("[TB] FAIL bp_first got=%h want=%h", {cycBus.ctrl_ready, cycBus.outs}, 13'h17FF);
    end
    cycBus.outs_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({cycBus.outs_valid, cycBus.ctrl_ready, cycBus.outs} !== {1'b1, 1'b0, 12'h7FF}) begin
        errors++;
        $display("[TB] FAIL bp_stall[%0d] got=%h want=%h", k, {cycBus.outs_valid, cycBus.ctrl_ready, cycBus.outs}, 14'h27FF);
      end
    end
    cycBus.outs_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({cycBus.ctrl_ready, cycBus.outs} !== {1'b1, 12'h800}) begin
      errors++;
      $display("[TB] FAIL bp_skid_drain got=%h want=%h", {cycBus.ctrl_ready, cycBus.outs}, 13'h1800);
    end
    @(negedge clk);
    cycBus.ctrl_valid = 1'b0;
    checks++;
    if ({cycBus.outs_valid, cycBus.outs} !== {1'b1, 12'hF32}) begin
      errors++;
      $display("[TB] FAIL bp_resume got=%h want=%h", {cycBus.outs_valid, cycBus.outs}, 13'h1F32);
    end
    @(negedge clk);
    checks++;
    if (cycBus.outs_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_empty got=%b want=0", cycBus.outs_valid);
    end
  endtask

  task automatic test_fixed();
    fixBus.ctrl_valid = 1'b1;
    fixBus.outs_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({fixBus.outs_valid, fixBus.outs} !== {1'b1, 12'hF32}) begin
        errors++;
        $display("[TB] FAIL fixed[%0d] got=%h want=%h", k, {fixBus.outs_valid, fixBus.outs}, 13'h1F32);
      end
    end
    fixBus.ctrl_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fixBus.outs_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fixed_drain got=%b want=0", fixBus.outs_valid);
    end
  endtask

  task automatic test_reset_midflight();
    cycBus.ctrl_valid = 1'b1;
    cycBus.outs_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({cycBus.outs_valid, cycBus.outs} !== {1'b1, 12'h123}) begin
      errors++;
      $display("[TB] FAIL mid_main got=%h want=%h", {cycBus.outs_valid, cycBus.outs}, 13'h1123);
    end
    @(negedge clk);
    checks++;
    if (cycBus.ctrl_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_full got=%b want=0", cycBus.ctrl_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cycBus.outs_valid, cycBus.ctrl_ready, cycBus.outs} !== 14'h0) begin
      errors++;
      $display("[TB] FAIL async_reset got=%h want=0", {cycBus.outs_valid, cycBus.ctrl_ready, cycBus.outs});
    end
    cycBus.ctrl_valid = 1'b0;
    cycBus.outs_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cycBus.ctrl_ready, cycBus.outs_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL post_reset got=%b want=10", {cycBus.ctrl_ready, cycBus.outs_valid});
    end
    cycBus.ctrl_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (cycBus.outs !== 12'hF32) begin
      errors++;
      $display("[TB] FAIL post_reset_tok0 got=%h want=f32", cycBus.outs);
    end
    @(negedge clk);
    cycBus.ctrl_valid = 1'b0;
    checks++;
    if (cycBus.outs !== 12'h0A5) begin
      errors++;
      $display("[TB] FAIL post_reset_init got=%h want=0a5", cycBus.outs);
    end
    @(negedge clk);
  endtask

  initial begin
    cycBus.ctrl_valid = 1'b0;
    cycBus.outs_ready = 1'b0;
    fixBus.ctrl_valid = 1'b0;
    fixBus.outs_ready = 1'b0;
    test_reset();
    test_cycle_stream();
    test_idx_clear();
    test_write();
    test_backpressure();
    test_fixed();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/handshake_constant_table.md
# handshake_constant_table

Elastic handshake constant source. Each token accepted on the `ctrl` channel emits one data token on `outs`, taken from a small register table of constants. The table can be stepped per token, rewritten at run time and restarted. The output is fully registered through a two-entry skid stage, which breaks both the valid and ready combinational paths. It sits in dataflow circuits wherever a control token must be turned into a constant operand, such as a coefficient, threshold or clip level.

## Interface
- `DATA_WIDTH`, 32: width of each constant and of `outs`.
- `DEPTH`, 4: number of table entries, ≥1; `IDX_W = max(1, clog2(DEPTH))`.
- `INIT`, all zero: packed `DEPTH*DATA_WIDTH` reset contents; entry i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `MODE`, 1: 0 = FIXED (always entry 0); 1 = CYCLE (step the index per accepted token, wrapping at DEPTH).

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ctrl_valid`  in  1  input token present.
- `ctrl_ready`  out  1  input token accepted this cycle.
- `outs`  out  DATA_WIDTH  constant value.
- `outs_valid`  out  1  output token present.
- `outs_ready`  in  1  consumer accepts.
- `idx_clear`  in  1  synchronous index restart to 0.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  IDX_W  entry to write; values ≥DEPTH are ignored.
- `wr_data`  in  DATA_WIDTH  value to write.

## Operation
- Accept: `ctrl_valid && ctrl_ready`. The token value is `table[idx]` at the accepting cycle, where idx is forced to 0 in FIXED mode.
- CYCLE mode: after an accept, idx = (idx==DEPTH-1) ? 0 : idx+1. DEPTH=1 makes the index always 0.
- `idx_clear`: next idx = 0. It overrides the increment when it coincides with an accept; that accepted token still uses the pre-clear idx.
- Table write: `table[wr_addr] <= wr_data`.
  - Read-before-write: an accept in the same cycle that reads the same entry gets the old value.
  - The next accept gets the new value.
- Output stage uses a main register plus a skid register:
  - `ctrl_ready` is registered and equals "skid empty".
  - Tokens leave strictly in order.
  - No token is dropped or duplicated.
- `ctrl_valid` without `ctrl_ready`: no state change.

## Timing
- Reset values:
  - `outs_valid`=0, `outs`=0, `ctrl_ready`=0.
  - idx=0, table=`INIT`, both buffer slots empty.
- First cycle after `rst` deasserts: `ctrl_ready`=1.
- Latency: 1 cycle. A token accepted at edge N is valid on `outs` after edge N.
- Throughput: 1 token/cycle with `outs_ready` held high.
- Back-pressure:
  - When `outs_ready` drops with the main register full, the next accepted token goes to skid.
  - `ctrl_ready` falls the following cycle.
  - When `outs_ready` returns, skid drains to main and `ctrl_ready` rises one cycle later.
- Output is stable while waiting: `outs`/`outs_valid` must not change while `outs_valid && !outs_ready`.
- Reset mid-operation clears immediately and asynchronously:
  - In-flight tokens are discarded.
  - Table returns to INIT and idx to 0.
  - `outs_valid`=0 without waiting for the clock.

## Structure
- Package `handshake_const_pkg`:
  - Mode constants `HC_MODE_FIXED`=0 and `HC_MODE_CYCLE`=1.
  - `idx_width(depth)` function.
- Sub-module `handshake_skid_buffer #(DATA_WIDTH)`:
  - Generic two-entry elastic register with registered ready.
  - Reused later by other handshake units.
- Top level holds the table registers, the index counter and the write port.

## Test plan
Bench configuration: DATA_WIDTH=12, DEPTH=4, INIT={0x800,0x7FF,0x0A5,0xF32}, so entry0=0xF32.

- CYCLE, `ctrl_valid` and `outs_ready` held high for 6 cycles → `outs` = 0xF32, 0x0A5, 0x7FF, 0x800, 0xF32, 0x0A5 on consecutive cycles, first one 1 cycle after the first accept.
- MODE=0, 3 tokens → 0xF32 three times; idx stays 0.
- `outs_ready` low for 3 cycles during a stream → exactly 2 tokens are held (main + skid); `ctrl_ready` is 0 from the second stalled cycle; `outs` stays stable; the order after release is unbroken.
- `wr_en`, addr 1, data 0x123 in the same cycle as the accept of idx 1 → that token is 0x0A5; the next visit to idx 1 gives 0x123.
- `idx_clear` together with the accept at idx 2 → that token is 0x7FF; the next token is 0xF32.
- `rst` asserted with both slots full → `outs_valid`=0 asynchronously; after release the first token is 0xF32 and the table is back to INIT.
